// File: rtl/fp_special_pkg.sv
// Shared types for the FP add/sub special-case unit.
// Operand classes, the resolve bundle and a canonical qNaN builder.
package fp_special_pkg;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_QNAN,
        FP_SNAN
    } fp_class_t;

    typedef struct packed {
        logic spe;
        logic sign;
        logic nv;
    } fp_resolve_t;

    localparam int QNAN_BITS_W = 128;

    // Bit image {sign=0, exp all-ones, mant MSB set}, right-aligned.
    function automatic logic [QNAN_BITS_W-1:0] canon_qnan(
        input int exp_w,
        input int mant_w
    );
        logic [QNAN_BITS_W-1:0] r;
        r = '0;
        for (int i = 0; i < QNAN_BITS_W; i++) begin
            if (i == mant_w - 1) r[i] = 1'b1;
            if (i >= mant_w && i < mant_w + exp_w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_operand_classify.sv
// Combinational operand classifier.
// Maps exponent/mantissa fields to an fp_class_t.
module fp_operand_classify
    import fp_special_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W-1:0] i_mant,
    output fp_class_t         o_class
);

    logic w_exp_ones;
    logic w_exp_zero;
    logic w_mant_zero;

    assign w_exp_ones  = &i_exp;
    assign w_exp_zero  = ~|i_exp;
    assign w_mant_zero = ~|i_mant;

    // Class decode; mantissa MSB separates quiet from signalling NaN.
    always_comb begin
        o_class = FP_NORM;
        if (w_exp_ones) begin
            if (w_mant_zero)
                o_class = FP_INF;
            else if (i_mant[MANT_W-1])
                o_class = FP_QNAN;
            else
                o_class = FP_SNAN;
        end else if (w_exp_zero) begin
            o_class = w_mant_zero ? FP_ZERO : FP_SUB;
        end
    end

endmodule

// File: rtl/fp_addsub_special_pipe.sv
// Pipelined special-case resolver for the FP add/sub datapath.
// Classifies, resolves, then streams the result through a valid/ready chain.
module fp_addsub_special_pipe
    import fp_special_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int MANT_W     = 23,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_aos,
    input  logic              i_signA,
    input  logic [EXP_W-1:0]  i_expA,
    input  logic [MANT_W-1:0] i_mantA,
    input  logic              i_signB,
    input  logic [EXP_W-1:0]  i_expB,
    input  logic [MANT_W-1:0] i_mantB,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_spe_sig,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_nv,
    output logic              o_nv_sticky,
    input  logic              i_nv_clr
);

    localparam int LAST = PIPE_DEPTH - 1;
    localparam logic [QNAN_BITS_W-1:0] QNAN_ALL =
        canon_qnan(EXP_W, MANT_W);
    localparam logic [EXP_W-1:0]  QNAN_EXP  = QNAN_ALL[MANT_W +: EXP_W];
    localparam logic [MANT_W-1:0] QNAN_MANT = QNAN_ALL[MANT_W-1:0];
    localparam logic [EXP_W-1:0]  EXP_ONES  = '1;

    fp_class_t   w_cls_a;
    fp_class_t   w_cls_b;
    logic        w_sb_eff;
    logic        w_nan_a, w_nan_b, w_snan_a, w_snan_b;
    logic        w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    fp_resolve_t w_res;
    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W-1:0] w_mant;

    fp_operand_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
        .i_exp   (i_expA),
        .i_mant  (i_mantA),
        .o_class (w_cls_a)
    );

    fp_operand_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
        .i_exp   (i_expB),
        .i_mant  (i_mantB),
        .o_class (w_cls_b)
    );

    assign w_sb_eff = i_signB ^ ~i_aos;
    assign w_snan_a = (w_cls_a == FP_SNAN);
    assign w_snan_b = (w_cls_b == FP_SNAN);
    assign w_nan_a  = w_snan_a | (w_cls_a == FP_QNAN);
    assign w_nan_b  = w_snan_b | (w_cls_b == FP_QNAN);
    assign w_inf_a  = (w_cls_a == FP_INF);
    assign w_inf_b  = (w_cls_b == FP_INF);
    assign w_zero_a = (w_cls_a == FP_ZERO);
    assign w_zero_b = (w_cls_b == FP_ZERO);

    // Priority resolution of special operand combinations.
    always_comb begin
        w_res  = '0;
        w_exp  = '0;
        w_mant = '0;
        if (w_nan_a | w_nan_b) begin
            w_res.spe = 1'b1;
            w_res.nv  = w_snan_a | w_snan_b;
            w_exp     = QNAN_EXP;
            w_mant    = QNAN_MANT;
        end else if (w_inf_a & w_inf_b) begin
            w_res.spe = 1'b1;
            if (i_signA != w_sb_eff) begin
                w_res.nv = 1'b1;
                w_exp    = QNAN_EXP;
                w_mant   = QNAN_MANT;
            end else begin
                w_res.sign = i_signA;
                w_exp      = EXP_ONES;
            end
        end else if (w_inf_a) begin
            w_res.spe  = 1'b1;
            w_res.sign = i_signA;
            w_exp      = EXP_ONES;
        end else if (w_inf_b) begin
            w_res.spe  = 1'b1;
            w_res.sign = w_sb_eff;
            w_exp      = EXP_ONES;
        end else if (w_zero_a & w_zero_b) begin
            w_res.spe  = 1'b1;
            w_res.sign = i_signA & w_sb_eff;
        end else if (w_zero_a) begin
            w_res.spe  = 1'b1;
            w_res.sign = w_sb_eff;
            w_exp      = i_expB;
            w_mant     = i_mantB;
        end else if (w_zero_b) begin
            w_res.spe  = 1'b1;
            w_res.sign = i_signA;
            w_exp      = i_expA;
            w_mant     = i_mantA;
        end
    end

    logic [PIPE_DEPTH-1:0] r_v;
    fp_resolve_t           r_res  [PIPE_DEPTH];
    logic [EXP_W-1:0]      r_exp  [PIPE_DEPTH];
    logic [MANT_W-1:0]     r_mant [PIPE_DEPTH];

    logic [PIPE_DEPTH-1:0] w_adv;
    logic [PIPE_DEPTH-1:0] w_load;
    logic                  w_ready;
    fp_resolve_t           w_in_res  [PIPE_DEPTH];
    logic [EXP_W-1:0]      w_in_exp  [PIPE_DEPTH];
    logic [MANT_W-1:0]     w_in_mant [PIPE_DEPTH];

    // Back-propagate space: a stage advances if everything below makes room.
    always_comb begin
        logic sp;
        sp    = i_ready;
        w_adv = '0;
        for (int k = LAST; k >= 0; k--) begin
            w_adv[k] = r_v[k] & sp;
            sp       = ~r_v[k] | sp;
        end
        w_ready = sp;
    end

    // Per-stage load enable and incoming payload.
    always_comb begin
        w_load       = '0;
        w_load[0]    = i_valid & w_ready;
        w_in_res[0]  = w_res;
        w_in_exp[0]  = w_exp;
        w_in_mant[0] = w_mant;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            w_load[k]    = w_adv[k-1];
            w_in_res[k]  = r_res[k-1];
            w_in_exp[k]  = r_exp[k-1];
            w_in_mant[k] = r_mant[k-1];
        end
    end

    // Stage registers: load on entry, clear valid when contents leave.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_res[k]  <= '0;
                r_exp[k]  <= '0;
                r_mant[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (w_load[k]) begin
                    r_v[k]    <= 1'b1;
                    r_res[k]  <= w_in_res[k];
                    r_exp[k]  <= w_in_exp[k];
                    r_mant[k] <= w_in_mant[k];
                end else if (w_adv[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
        end
    end

    logic r_sticky;

    // Sticky invalid: set on an invalid transfer, set beats clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_sticky <= 1'b0;
        else if (o_valid & i_ready & o_nv)
            r_sticky <= 1'b1;
        else if (i_nv_clr)
            r_sticky <= 1'b0;
    end

    assign o_ready     = w_ready;
    assign o_valid     = r_v[LAST];
    assign o_spe_sig   = r_res[LAST].spe;
    assign o_sign      = r_res[LAST].sign;
    assign o_nv        = r_res[LAST].nv;
    assign o_exp       = r_exp[LAST];
    assign o_mant      = r_mant[LAST];
    assign o_nv_sticky = r_sticky;

endmodule

// File: tb/tb_fp_addsub_special_pipe.sv
// Bench for fp_addsub_special_pipe: binary32/depth 2 and binary64/depth 1.
// Scoreboarded random stream plus literal directed cases.
module tb_fp_addsub_special_pipe;

    typedef struct packed {
        logic        spe;
        logic        sign;
        logic [10:0] exp;
        logic [51:0] mant;
        logic        nv;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // binary32, depth 2
    logic        a_valid, a_ordy, a_aos, a_sa, a_sb, a_oval, a_rdy;
    logic [7:0]  a_ea, a_eb, a_oe;
    logic [22:0] a_ma, a_mb, a_om;
    logic        a_spe, a_os, a_nv, a_stky, a_clr;

    // binary64, depth 1
    logic        b_valid, b_ordy, b_aos, b_sa, b_sb, b_oval, b_rdy;
    logic [10:0] b_ea, b_eb, b_oe;
    logic [51:0] b_ma, b_mb, b_om;
    logic        b_spe, b_os, b_nv, b_stky, b_clr;

    fp_addsub_special_pipe #(.EXP_W(8), .MANT_W(23), .PIPE_DEPTH(2)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ordy),
        .i_aos(a_aos), .i_signA(a_sa), .i_expA(a_ea), .i_mantA(a_ma),
        .i_signB(a_sb), .i_expB(a_eb), .i_mantB(a_mb),
        .o_valid(a_oval), .i_ready(a_rdy), .o_spe_sig(a_spe),
        .o_sign(a_os), .o_exp(a_oe), .o_mant(a_om), .o_nv(a_nv),
        .o_nv_sticky(a_stky), .i_nv_clr(a_clr)
    );

    fp_addsub_special_pipe #(.EXP_W(11), .MANT_W(52), .PIPE_DEPTH(1)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ordy),
        .i_aos(b_aos), .i_signA(b_sa), .i_expA(b_ea), .i_mantA(b_ma),
        .i_signB(b_sb), .i_expB(b_eb), .i_mantB(b_mb),
        .o_valid(b_oval), .i_ready(b_rdy), .o_spe_sig(b_spe),
        .o_sign(b_os), .o_exp(b_oe), .o_mant(b_om), .o_nv(b_nv),
        .o_nv_sticky(b_stky), .i_nv_clr(b_clr)
    );

    // Reference: IEEE special-case rules over plain field arithmetic.
    function automatic res_t model(input int ew, input int mw,
                                   input logic aos,
                                   input logic sa, input logic [10:0] ea,
                                   input logic [51:0] ma,
                                   input logic sb, input logic [10:0] eb,
                                   input logic [51:0] mb);
        res_t r;
        longint emax;
        logic sbe;
        bit nan_a, nan_b, sn_a, sn_b, inf_a, inf_b, z_a, z_b;
        emax  = (64'd1 << ew) - 1;
        sbe   = sb ^ ~aos;
        nan_a = (ea == emax) && (ma != 0);
        nan_b = (eb == emax) && (mb != 0);
        sn_a  = nan_a && (ma[mw-1] == 1'b0);
        sn_b  = nan_b && (mb[mw-1] == 1'b0);
        inf_a = (ea == emax) && (ma == 0);
        inf_b = (eb == emax) && (mb == 0);
        z_a   = (ea == 0) && (ma == 0);
        z_b   = (eb == 0) && (mb == 0);
        r = '0;
        if (nan_a || nan_b || (inf_a && inf_b && sa != sbe)) begin
            r.spe  = 1'b1;
            r.exp  = emax[10:0];
            r.mant = 52'd1 << (mw - 1);
            r.nv   = (nan_a || nan_b) ? (sn_a || sn_b) : 1'b1;
        end else if (inf_a || inf_b) begin
            r.spe  = 1'b1;
            r.exp  = emax[10:0];
            r.sign = inf_a ? sa : sbe;
        end else if (z_a && z_b) begin
            r.spe  = 1'b1;
            r.sign = sa && sbe;
        end else if (z_a) begin
            r.spe = 1'b1; r.sign = sbe; r.exp = eb; r.mant = mb;
        end else if (z_b) begin
            r.spe = 1'b1; r.sign = sa; r.exp = ea; r.mant = ma;
        end
        return r;
    endfunction

    task automatic gen_op(input int ew, input int mw, output logic s,
                          output logic [10:0] e, output logic [51:0] m);
        logic [63:0] mmask, rnd;
        int emaxi, c;
        emaxi = (1 << ew) - 1;
        mmask = (64'd1 << mw) - 1;
        rnd   = {$urandom, $urandom} & mmask;
        s     = 1'($urandom_range(0, 1));
        c     = $urandom_range(0, 7);
        case (c)
            0: begin e = '0; m = '0; end
            1: begin e = '0; m = rnd[51:0] | 52'd1; end
            4: begin e = 11'(emaxi); m = '0; end
            5: begin e = 11'(emaxi); m = rnd[51:0] | (52'd1 << (mw - 1)); end
            6: begin
                e = 11'(emaxi);
                m = rnd[51:0] & ~(52'd1 << (mw - 1));
                if (m == 0) m = 52'd1;
            end
            default: begin e = 11'($urandom_range(1, emaxi - 1)); m = rnd[51:0]; end
        endcase
    endtask

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Scoreboard for dut32: checks every transfer, stalls and sticky flag.
    res_t q[$];
    logic exp_sticky = 1'b0;
    bit   stall_prev = 0;
    res_t held;
    always @(negedge clk) begin
        res_t got, e;
        logic xnv;
        if (!rst_n) begin
            q.delete();
            exp_sticky = 1'b0;
            stall_prev = 0;
        end else begin
            got = '{spe: a_spe, sign: a_os, exp: {3'b0, a_oe},
                    mant: {29'b0, a_om}, nv: a_nv};
            if (stall_prev) begin
                total++;
                if (!a_oval || got !== held) begin
                    bad++;
                    $display("FAIL stall_hold got=%h want=%h", got, held);
                end
            end
            stall_prev = a_oval && !a_rdy;
            held = got;
            total++;
            if (a_stky !== exp_sticky) begin
                bad++;
                $display("FAIL sticky got=%b want=%b", a_stky, exp_sticky);
            end
            xnv = 1'b0;
            if (a_oval && a_rdy) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat got=%h want=none", got);
                end else begin
                    e = q.pop_front();
                    xnv = e.nv;
                    if (got !== e) begin
                        bad++;
                        $display("FAIL result got=%h want=%h", got, e);
                    end
                end
            end
            exp_sticky = xnv | (exp_sticky & ~a_clr);
            if (a_valid && a_ordy)
                q.push_back(model(8, 23, a_aos, a_sa, {3'b0, a_ea},
                                  {29'b0, a_ma}, a_sb, {3'b0, a_eb},
                                  {29'b0, a_mb}));
        end
    end

    task automatic send32(input logic aos, input logic sa, input logic [7:0] ea,
                          input logic [22:0] ma, input logic sb,
                          input logic [7:0] eb, input logic [22:0] mb);
        bit ok;
        a_aos = aos; a_sa = sa; a_ea = ea; a_ma = ma;
        a_sb = sb; a_eb = eb; a_mb = mb;
        a_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = a_ordy;
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        if (!ok) chk("send32_timeout", 64'd0, 64'd1);
    endtask

    // Empty pipe, i_ready=1: nothing after 1 cycle, literal result after 2.
    task automatic dir32(input string nm, input logic aos,
                         input logic sa, input logic [7:0] ea,
                         input logic [22:0] ma, input logic sb,
                         input logic [7:0] eb, input logic [22:0] mb,
                         input logic spe, input logic sg, input logic [7:0] ee,
                         input logic [22:0] em, input logic nv);
        send32(aos, sa, ea, ma, sb, eb, mb);
        @(negedge clk);
        chk({nm, "_lat1"}, 64'(a_oval), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(a_oval), 64'd1);
        chk({nm, "_res"}, {a_spe, a_os, a_oe, a_om, a_nv},
            {spe, sg, ee, em, nv});
        @(posedge clk);
        #1;
    endtask

    task automatic dir64(input string nm, input logic aos,
                         input logic sa, input logic [10:0] ea,
                         input logic [51:0] ma, input logic sb,
                         input logic [10:0] eb, input logic [51:0] mb,
                         input res_t want);
        bit ok;
        b_aos = aos; b_sa = sa; b_ea = ea; b_ma = ma;
        b_sb = sb; b_eb = eb; b_mb = mb;
        b_valid = 1'b1;
        @(negedge clk);
        ok = b_ordy;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        chk({nm, "_acc"}, 64'(ok), 64'd1);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(b_oval), 64'd1);
        chk({nm, "_spe"}, {b_spe, b_os, b_nv}, {want.spe, want.sign, want.nv});
        chk({nm, "_exp"}, 64'(b_oe), 64'(want.exp));
        chk({nm, "_mant"}, 64'(b_om), 64'(want.mant));
        @(posedge clk);
        #1;
    endtask

    initial begin
        res_t w;
        logic s1, s2;
        logic [10:0] e1, e2;
        logic [51:0] m1, m2;
        bit acc;
        int sent;

        rst_n = 1'b0;
        a_valid = 0; a_aos = 1; a_sa = 0; a_sb = 0; a_ea = 0; a_eb = 0;
        a_ma = 0; a_mb = 0; a_rdy = 1; a_clr = 0;
        b_valid = 0; b_aos = 1; b_sa = 0; b_sb = 0; b_ea = 0; b_eb = 0;
        b_ma = 0; b_mb = 0; b_rdy = 1; b_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ovalid", 64'(a_oval), 64'd0);
        chk("rst_a_oready", 64'(a_ordy), 64'd1);
        chk("rst_a_data", {a_spe, a_os, a_oe, a_om, a_nv, a_stky}, 64'd0);
        chk("rst_b_ovalid", 64'(b_oval), 64'd0);
        chk("rst_b_oready", 64'(b_ordy), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dir32("infpinfm", 1, 0, 8'hFF, 0, 1, 8'hFF, 0, 1, 0, 8'hFF, 23'h400000, 1);
        @(negedge clk);
        chk("sticky_set", 64'(a_stky), 64'd1);
        @(posedge clk);
        #1;
        dir32("sub_minf_pinf", 0, 1, 8'hFF, 0, 0, 8'hFF, 0, 1, 1, 8'hFF, 0, 0);
        dir32("sub_p0_p0", 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        dir32("add_m0_m0", 1, 1, 8'h00, 0, 1, 8'h00, 0, 1, 1, 8'h00, 0, 0);
        dir32("snan_one", 1, 0, 8'hFF, 23'h1, 0, 8'h7F, 0, 1, 0, 8'hFF, 23'h400000, 1);
        dir32("qnan_one", 1, 1, 8'hFF, 23'h400000, 0, 8'h7F, 0, 1, 0, 8'hFF, 23'h400000, 0);
        dir32("one_two", 1, 0, 8'h7F, 0, 0, 8'h80, 0, 0, 0, 8'h00, 0, 0);
        dir32("zero_b_pass", 0, 1, 8'h00, 0, 0, 8'h85, 23'h12345, 1, 1, 8'h85, 23'h12345, 0);

        // Backpressure: fill, stall three cycles, then drain.
        a_rdy = 1'b0;
        send32(1, 0, 8'h00, 0, 1, 8'h10, 23'h1);
        send32(0, 1, 8'h20, 23'h2, 0, 8'h00, 0);
        chk("full_oready", 64'(a_ordy), 64'd0);
        a_valid = 1'b1;
        a_aos = 1; a_sa = 0; a_ea = 8'hFF; a_ma = 0;
        a_sb = 0; a_eb = 8'h01; a_mb = 0;
        @(posedge clk);
        #1;
        a_rdy = 1'b1;
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = a_ordy;
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        chk("stall_accept", 64'(acc), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);

        // Clear, then clear coincident with an invalid transfer.
        a_clr = 1'b1;
        @(posedge clk);
        #1;
        a_clr = 1'b0;
        @(negedge clk);
        chk("clr_sticky", 64'(a_stky), 64'd0);
        @(posedge clk);
        #1;
        send32(1, 0, 8'hFF, 0, 1, 8'hFF, 0);
        @(posedge clk);
        #1;
        a_clr = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("set_wins_clr", 64'(a_stky), 64'd1);
        @(posedge clk);
        #1;
        a_clr = 1'b0;
        @(negedge clk);
        chk("clr_next", 64'(a_stky), 64'd0);
        @(posedge clk);
        #1;

        // Random stream with random backpressure and clears.
        sent = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (sent >= 400 && !a_valid && q.size() == 0) break;
            @(negedge clk);
            acc = a_valid && a_ordy;
            @(posedge clk);
            #1;
            if (acc) a_valid = 1'b0;
            a_rdy = ($urandom_range(0, 3) != 0);
            a_clr = ($urandom_range(0, 15) == 0);
            if (!a_valid && sent < 400 && $urandom_range(0, 3) != 0) begin
                gen_op(8, 23, s1, e1, m1);
                gen_op(8, 23, s2, e2, m2);
                a_aos = 1'($urandom_range(0, 1));
                a_sa = s1; a_ea = e1[7:0]; a_ma = m1[22:0];
                a_sb = s2; a_eb = e2[7:0]; a_mb = m2[22:0];
                a_valid = 1'b1;
                sent++;
            end
        end
        a_rdy = 1'b1;
        a_clr = 1'b0;
        chk("random_drained", {32'(q.size()), 31'd0, a_valid}, 64'd0);

        // Reset mid-stream drops in-flight beats.
        a_rdy = 1'b0;
        send32(1, 0, 8'h00, 0, 0, 8'h01, 0);
        send32(1, 0, 8'h00, 0, 0, 8'h02, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ovalid", 64'(a_oval), 64'd0);
        chk("midrst_oready", 64'(a_ordy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_rdy = 1'b1;
        @(posedge clk);
        #1;

        // binary64, depth 1.
        w = '0;
        w.spe = 1; w.exp = 11'h7FF; w.mant = 52'h8000000000000; w.nv = 1;
        dir64("d64_infinf", 1, 0, 11'h7FF, 0, 1, 11'h7FF, 0, w);
        w = '0;
        w.spe = 1; w.sign = 1; w.exp = 11'h3FF; w.mant = 52'h1;
        dir64("d64_zero_b", 0, 0, 11'h000, 0, 0, 11'h3FF, 52'h1, w);
        for (int i = 0; i < 20; i++) begin
            gen_op(11, 52, s1, e1, m1);
            gen_op(11, 52, s2, e2, m2);
            acc = 1'($urandom_range(0, 1));
            w = model(11, 52, acc, s1, e1, m1, s2, e2, m2);
            dir64("d64_rand", acc, s1, e1, m1, s2, e2, m2, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
